// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam int KEY_W = 128;
    localparam int IDX_W = 4;

    // Round index of the LOAD step: key 0 when encrypting, key NR when decrypting.
    function automatic logic [IDX_W-1:0] first_idx(input logic mode, input int nr);
        return (mode == MODE_DEC) ? IDX_W'(nr) : '0;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake, key bus and datapath-control bundle between front end, sequencer and round datapath.
interface aes_round_sequencer_if #(
    parameter int NR   = 10,
    parameter int CNTW = 16
);
    import aes_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_mode;
    logic                      abort;
    logic [KEY_W*(NR+1)-1:0]   expanded_keys;
    logic [KEY_W-1:0]          round_key;
    logic [IDX_W-1:0]          round_idx;
    logic                      dp_load;
    logic                      dp_round_en;
    logic                      dp_last;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic [CNTW-1:0]           blk_count;

    modport master (
        output in_valid, in_mode, abort, expanded_keys, out_ready,
        input  in_ready, round_key, round_idx, dp_load, dp_round_en, dp_last,
               out_valid, busy, blk_count
    );

    modport slave (
        input  in_valid, in_mode, abort, expanded_keys, out_ready,
        output in_ready, round_key, round_idx, dp_load, dp_round_en, dp_last,
               out_valid, busy, blk_count
    );

endinterface

// File: rtl/aes_round_key_select.sv
// NR+1-way round-key mux; drives zero whenever the datapath is not being stepped.
module aes_round_key_select
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                    en_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [KEY_W*(NR+1)-1:0] keys_i,
    output logic [KEY_W-1:0]        key_o
);

    // Compare against each legal index so an out-of-range idx can never select past the bus.
    always_comb begin
        key_o = '0;
        if (en_i) begin
            for (int k = 0; k <= NR; k++) begin
                if (idx_i == IDX_W'(k)) begin
                    key_o = keys_i[KEY_W*k +: KEY_W];
                end
            end
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM stepping one iterative AES round datapath through NR+1 round-key steps per block.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR   = 10,
    parameter int NK   = 4,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_round_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] IDX_NR      = IDX_W'(NR);
    localparam logic [IDX_W-1:0] IDX_PENULT  = IDX_W'(NR - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

    // Key length and round count must describe the same AES variant.
    if (NR != NK + 6 || !(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_cfg
        $error("aes_round_sequencer: illegal NR/NK combination");
    end

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    logic               in_ready;
    logic               dp_load;
    logic               dp_round_en;
    logic               dp_last;
    logic               out_valid;
    logic               busy;
    logic               key_en;
    logic [KEY_W-1:0]   round_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_ENC;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        // Abort cancels anything in flight; in IDLE it is ignored so an accept still wins.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_d = LOAD;
                        mode_d  = bus.in_mode;
                        idx_d   = first_idx(bus.in_mode, NR);
                    end
                end
                LOAD: begin
                    state_d = ROUND;
                    idx_d   = (mode_q == MODE_DEC) ? IDX_PENULT : IDX_ONE;
                end
                ROUND: begin
                    if (mode_q == MODE_DEC) begin
                        if (idx_q == IDX_ONE) begin
                            state_d = FINAL;
                            idx_d   = '0;
                        end else begin
                            idx_d   = idx_q - IDX_ONE;
                        end
                    end else begin
                        if (idx_q == IDX_PENULT) begin
                            state_d = FINAL;
                            idx_d   = IDX_NR;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                        end
                    end
                end
                FINAL: begin
                    state_d = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_last     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD:    dp_load     = 1'b1;
            ROUND:   dp_round_en = 1'b1;
            FINAL:   dp_last     = 1'b1;
            DONE:    out_valid   = 1'b1;
            default: busy        = 1'b0;
        endcase
    end

    assign key_en = dp_load | dp_round_en | dp_last;

    aes_round_key_select #(
        .NR (NR)
    ) u_key_select (
        .en_i   (key_en),
        .idx_i  (idx_q),
        .keys_i (bus.expanded_keys),
        .key_o  (round_key)
    );

    assign bus.in_ready    = in_ready;
    assign bus.round_key   = round_key;
    assign bus.round_idx   = idx_q;
    assign bus.dp_load     = dp_load;
    assign bus.dp_round_en = dp_round_en;
    assign bus.dp_last     = dp_last;
    assign bus.out_valid   = out_valid;
    assign bus.busy        = busy;
    assign bus.blk_count   = cnt_q;

endmodule
